// File: rtl/pipe_stall_ctrl.sv
// Pipeline sequencer for the 5-stage core: stage enables/flushes for load-use stalls,
// taken-branch flushes and multi-cycle data-memory accesses, plus a stall-cycle counter.
module pipe_stall_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_uses_rs,
  input  logic             ID_uses_rt,
  input  logic             EXE_RegW,
  input  logic             EXE_RegW_Src,
  input  logic [4:0]       EXE_WBdst,
  input  logic             EXE_br_taken,
  input  logic             MEM_MemW,
  input  logic             MEM_RegW_Src,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idexe_en,
  output logic             idexe_flush,
  output logic             exemem_en,
  output logic             memwb_en,
  output logic             memwb_flush,
  output logic             mem_req,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic [WAIT_W-1:0] wait_cnt_nxt_s;
  logic              mem_err_r;
  logic              mem_err_nxt_s;
  logic [CNT_W-1:0]  stall_cnt_r;

  logic mem_access_s;
  logic load_use_s;
  logic rs_hit_s;
  logic rt_hit_s;

  // Control vector the RUN state would produce for the current inputs.
  logic run_pc_en_s, run_ifid_en_s, run_ifid_flush_s, run_idexe_en_s, run_idexe_flush_s;
  logic run_exemem_en_s, run_memwb_en_s, run_memwb_flush_s;

  // Combinational control vector after state and reset gating.
  logic pc_en_s, ifid_en_s, ifid_flush_s, idexe_en_s, idexe_flush_s;
  logic exemem_en_s, memwb_en_s, memwb_flush_s, mem_req_s;

  assign mem_access_s = MEM_MemW | MEM_RegW_Src;
  assign rs_hit_s     = ID_uses_rs & (ID_rs == EXE_WBdst);
  assign rt_hit_s     = ID_uses_rt & (ID_rt == EXE_WBdst);
  assign load_use_s   = EXE_RegW & EXE_RegW_Src & (EXE_WBdst != 5'd0) & (rs_hit_s | rt_hit_s);

  // RUN-state control decode; memory stall beats branch, branch beats load-use.
  always_comb begin
    run_pc_en_s       = 1'b1;
    run_ifid_en_s     = 1'b1;
    run_ifid_flush_s  = 1'b0;
    run_idexe_en_s    = 1'b1;
    run_idexe_flush_s = 1'b0;
    run_exemem_en_s   = 1'b1;
    run_memwb_en_s    = 1'b1;
    run_memwb_flush_s = 1'b0;
    if (mem_access_s && !mem_ready) begin
      run_pc_en_s       = 1'b0;
      run_ifid_en_s     = 1'b0;
      run_idexe_en_s    = 1'b0;
      run_exemem_en_s   = 1'b0;
      run_memwb_en_s    = 1'b0;
      run_memwb_flush_s = 1'b1;
    end else if (EXE_br_taken) begin
      // A coincident load-use is dropped: its consumer is flushed here anyway.
      run_ifid_flush_s  = 1'b1;
      run_idexe_flush_s = 1'b1;
    end else if (load_use_s) begin
      run_pc_en_s       = 1'b0;
      run_ifid_en_s     = 1'b0;
      run_idexe_flush_s = 1'b1;
    end else begin
      run_pc_en_s       = 1'b1;
    end
  end

  // Next-state logic and state-dependent output selection.
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    mem_err_nxt_s  = mem_err_r;
    pc_en_s        = 1'b0;
    ifid_en_s      = 1'b0;
    ifid_flush_s   = 1'b0;
    idexe_en_s     = 1'b0;
    idexe_flush_s  = 1'b0;
    exemem_en_s    = 1'b0;
    memwb_en_s     = 1'b0;
    memwb_flush_s  = 1'b1;
    mem_req_s      = 1'b0;
    case (state_r)
      ST_RUN: begin
        pc_en_s       = run_pc_en_s;
        ifid_en_s     = run_ifid_en_s;
        ifid_flush_s  = run_ifid_flush_s;
        idexe_en_s    = run_idexe_en_s;
        idexe_flush_s = run_idexe_flush_s;
        exemem_en_s   = run_exemem_en_s;
        memwb_en_s    = run_memwb_en_s;
        memwb_flush_s = run_memwb_flush_s;
        mem_req_s     = mem_access_s;
        if (mem_access_s && !mem_ready) begin
          state_nxt_s    = ST_MEM_WAIT;
          wait_cnt_nxt_s = WAIT_W'(1);
        end else begin
          state_nxt_s    = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        mem_req_s = mem_access_s;
        if (mem_ready) begin
          // Completion cycle behaves exactly like RUN with a finished access.
          pc_en_s        = run_pc_en_s;
          ifid_en_s      = run_ifid_en_s;
          ifid_flush_s   = run_ifid_flush_s;
          idexe_en_s     = run_idexe_en_s;
          idexe_flush_s  = run_idexe_flush_s;
          exemem_en_s    = run_exemem_en_s;
          memwb_en_s     = run_memwb_en_s;
          memwb_flush_s  = run_memwb_flush_s;
          state_nxt_s    = ST_RUN;
          wait_cnt_nxt_s = '0;
        end else if (wait_cnt_r == WAIT_W'(MEM_TIMEOUT)) begin
          state_nxt_s    = ST_HALT;
          mem_err_nxt_s  = 1'b1;
        end else begin
          wait_cnt_nxt_s = wait_cnt_r + WAIT_W'(1);
        end
      end
      ST_HALT: begin
        state_nxt_s = ST_HALT;
      end
      default: begin
        state_nxt_s    = ST_HALT;
        mem_err_nxt_s  = 1'b1;
      end
    endcase
    if (!rst) begin
      // Reset drives all stages to hold a bubble and drops any pending request.
      pc_en_s       = 1'b0;
      ifid_en_s     = 1'b0;
      ifid_flush_s  = 1'b1;
      idexe_en_s    = 1'b0;
      idexe_flush_s = 1'b1;
      exemem_en_s   = 1'b0;
      memwb_en_s    = 1'b0;
      memwb_flush_s = 1'b1;
      mem_req_s     = 1'b0;
    end else begin
      mem_req_s     = mem_req_s;
    end
  end

  // Sequencer state, wait counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_RUN;
      wait_cnt_r <= '0;
      mem_err_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
      mem_err_r  <= mem_err_nxt_s;
    end
  end

  // Saturating count of cycles in which the PC is held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r <= '0;
    end else if (!pc_en_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign pc_en       = pc_en_s;
  assign ifid_en     = ifid_en_s;
  assign ifid_flush  = ifid_flush_s;
  assign idexe_en    = idexe_en_s;
  assign idexe_flush = idexe_flush_s;
  assign exemem_en   = exemem_en_s;
  assign memwb_en    = memwb_en_s;
  assign memwb_flush = memwb_flush_s;
  assign mem_req     = mem_req_s;
  assign mem_err     = mem_err_r;
  assign stall_cnt   = stall_cnt_r;

endmodule
